gpca_op_sequencer: RTL

//  Upstream command stage for the 5-row gpca pipelined array. Accepts one integer op
//  (MUL, SQR, SQRT, DIV) per handshake and formats operands into the array's X/P/A/B/C

---
 rtl/gpca_op_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/gpca_op_sequencer.sv
// Command sequencer in front of the 5-row gpca array: formats one op into the
// array's X/P/A/B/C fields, holds them for the array settle time, captures F/S
// and offers the result downstream through a valid/ready handshake.
module gpca_op_sequencer #(
  parameter int ARRAY_LAT = 5,
  parameter int NP        = 5,
  parameter int NBC       = 7,
  parameter int NA        = 10,
  parameter int NS        = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [1:0]     op_code,
  input  logic [9:0]     op_a,
  input  logic [4:0]     op_b,
  output logic           arr_x,
  output logic [NP-1:0]  arr_p,
  output logic [NA-1:0]  arr_a,
  output logic [NBC-1:0] arr_b,
  output logic [NBC-1:0] arr_c,
  input  logic [NP-1:0]  arr_f,
  input  logic [NS-1:0]  arr_s,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [NP-1:0]  res_f,
  output logic [NS-1:0]  res_s,
  output logic           res_err
);

  localparam int CW = $clog2(ARRAY_LAT + 1);

  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_SQR  = 2'd1;
  localparam logic [1:0] OP_SQRT = 2'd2;
  localparam logic [1:0] OP_DIV  = 2'd3;

  typedef enum logic [1:0] {IDLE, HOLD, CAPT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             x_reg, x_next;
  logic [NP-1:0]    p_reg, p_next;
  logic [NA-1:0]    a_reg, a_next;
  logic [NBC-1:0]   b_reg, b_next;
  logic [NBC-1:0]   c_reg, c_next;
  logic [NP-1:0]    f_reg, f_next;
  logic [NS-1:0]    s_reg, s_next;
  logic             err_reg, err_next;

  // Operand fields for the op currently presented (only used on accept)
  logic             fmt_x;
  logic [NP-1:0]    fmt_p;
  logic [NA-1:0]    fmt_a;
  logic [NBC-1:0]   fmt_b;
  logic [NBC-1:0]   fmt_c;
  logic             div_by_zero;

  // Translate the integer op into the array's X/P/A/B/C encoding
  always_comb begin
    fmt_x = 1'b0;
    fmt_p = '0;
    fmt_a = '0;
    fmt_b = '0;
    fmt_c = '0;
    case (op_code)
      OP_MUL: begin
        fmt_p = NP'(op_b[4:0]);
        fmt_b = NBC'({op_a[2:0], 4'b0000});
        fmt_c = NBC'({op_a[2:0], 4'b0000});
      end
      OP_SQR: begin
        fmt_p = NP'(op_a[4:0]);
        fmt_b = NBC'(7'b0011111);
        fmt_c = NBC'(7'b0100000);
      end
      OP_SQRT: begin
        fmt_x = 1'b1;
        fmt_a = NA'(op_a);
        fmt_b = NBC'(7'b0011111);
        fmt_c = NBC'(7'b0100000);
      end
      default: begin
        fmt_x = 1'b1;
        fmt_a = NA'({op_a[5:0], 4'b0000});
        fmt_b = NBC'({op_b[2:0], 4'b0000});
        fmt_c = NBC'({op_b[2:0], 4'b0000});
      end
    endcase
  end

  assign div_by_zero = (op_code == OP_DIV) && (op_b[2:0] == 3'd0);

  // Next-state and datapath update for the sequencer
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    x_next     = x_reg;
    p_next     = p_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    c_next     = c_reg;
    f_next     = f_reg;
    s_next     = s_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (op_valid) begin
          if (div_by_zero) begin
            // Array is never driven; report the error straight away
            err_next   = 1'b1;
            f_next     = '0;
            s_next     = '0;
            state_next = DONE;
          end else begin
            x_next     = fmt_x;
            p_next     = fmt_p;
            a_next     = fmt_a;
            b_next     = fmt_b;
            c_next     = fmt_c;
            cnt_next   = '0;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (cnt_reg == CW'(ARRAY_LAT - 1)) begin
          state_next = CAPT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      CAPT: begin
        f_next     = arr_f;
        s_next     = arr_s;
        err_next   = 1'b0;
        state_next = DONE;
      end
      default: begin
        if (res_ready) begin
          x_next     = 1'b0;
          p_next     = '0;
          a_next     = '0;
          b_next     = '0;
          c_next     = '0;
          state_next = IDLE;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      x_reg     <= 1'b0;
      p_reg     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      f_reg     <= '0;
      s_reg     <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      x_reg     <= x_next;
      p_reg     <= p_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      c_reg     <= c_next;
      f_reg     <= f_next;
      s_reg     <= s_next;
      err_reg   <= err_next;
    end
  end

  assign op_ready  = (state_reg == IDLE);
  assign res_valid = (state_reg == DONE);
  assign arr_x     = x_reg;
  assign arr_p     = p_reg;
  assign arr_a     = a_reg;
  assign arr_b     = b_reg;
  assign arr_c     = c_reg;
  assign res_f     = f_reg;
  assign res_s     = s_reg;
  assign res_err   = err_reg;

endmodule
